// File: rtl/move_sequencer.sv
// Move controller for the 4x4 node grid: launches a shift/merge wave, waits for the board
// to settle, spawns a new tile through the preset path, accumulates score and flags game over.
module move_sequencer #(
  parameter int          QUIET      = 4,
  parameter int          SETTLE_MAX = 64,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_req,
  input  logic [1:0]  move_dir,
  output logic        move_ack,
  input  logic [63:0] board,
  input  logic [15:0] node_score,
  input  logic [31:0] node_movable,
  output logic [3:0]  start_dir,
  output logic        preset,
  output logic [15:0] preset_sel,
  output logic [3:0]  preset_value,
  output logic [15:0] score,
  output logic        moved,
  output logic        busy,
  output logic        game_over,
  output logic [2:0]  dbg_state
);

  // Handshake: move_req is sampled only in IDLE (and only while game_over is low); acceptance
  // is answered by a one-cycle move_ack in the following cycle. Requests seen elsewhere are dropped.

  typedef enum logic [2:0] {
    S_INIT0  = 3'd0,
    S_INIT1  = 3'd1,
    S_IDLE   = 3'd2,
    S_START  = 3'd3,
    S_SETTLE = 3'd4,
    S_SPAWN  = 3'd5,
    S_POST   = 3'd6,
    S_CHECK  = 3'd7
  } state_t;

  localparam logic [6:0] QUIET_C  = 7'(QUIET);
  localparam logic [6:0] TMO_LAST = 7'(SETTLE_MAX - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [63:0] snap_q, prev_q;
  logic [6:0]  quiet_q, tmo_q;
  logic        scan_first_q;
  logic [3:0]  scan_cell_q, scan_cnt_q;
  logic        ret_init1_q, from_spawn_q;
  logic [15:0] score_q;
  logic        game_over_q;

  logic        ack_q, ack_d;
  logic [3:0]  start_dir_q, start_dir_d;
  logic        preset_q, preset_d;
  logic [15:0] preset_sel_q, preset_sel_d;
  logic [3:0]  preset_value_q, preset_value_d;
  logic        moved_q, moved_d;
  logic        busy_q, busy_d;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic        is_scan, cell_empty, scan_done, settle_exit, accept;
  logic [3:0]  probe_cell, probe_idx;
  logic [16:0] score_sum;

  // The first probe of a scan uses the live LFSR nibble as the start cell.
  assign is_scan     = (state_q == S_INIT0) || (state_q == S_INIT1) || (state_q == S_SPAWN);
  assign probe_cell  = scan_first_q ? lfsr_q[3:0] : scan_cell_q;
  assign probe_idx   = scan_first_q ? 4'd0 : scan_cnt_q;
  assign cell_empty  = (board[{probe_cell, 2'b00} +: 4] == 4'd0);
  assign scan_done   = is_scan && (cell_empty || (probe_idx == 4'd15));
  assign settle_exit = (quiet_q >= QUIET_C) || (tmo_q >= TMO_LAST);
  assign accept      = (state_q == S_IDLE) && move_req && !game_over_q;
  assign score_sum   = {1'b0, score_q} + {12'd0, popcount16(node_score)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_INIT0;
      lfsr_q         <= SEED;
      snap_q         <= '0;
      prev_q         <= '0;
      quiet_q        <= '0;
      tmo_q          <= '0;
      scan_first_q   <= 1'b1;
      scan_cell_q    <= '0;
      scan_cnt_q     <= '0;
      ret_init1_q    <= 1'b0;
      from_spawn_q   <= 1'b0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
      ack_q          <= 1'b0;
      start_dir_q    <= '0;
      preset_q       <= 1'b0;
      preset_sel_q   <= '0;
      preset_value_q <= '0;
      moved_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      prev_q         <= board;
      scan_first_q   <= (state_d != state_q);
      scan_cell_q    <= probe_cell + 4'd1;
      scan_cnt_q     <= probe_idx + 4'd1;
      ack_q          <= ack_d;
      start_dir_q    <= start_dir_d;
      preset_q       <= preset_d;
      preset_sel_q   <= preset_sel_d;
      preset_value_q <= preset_value_d;
      moved_q        <= moved_d;
      busy_q         <= busy_d;
      if (accept) snap_q <= board;
      if (scan_done) begin
        ret_init1_q  <= (state_q == S_INIT0);
        from_spawn_q <= (state_q == S_SPAWN);
      end
      if (state_q == S_START) begin
        quiet_q <= '0;
        tmo_q   <= '0;
      end else if (state_q == S_SETTLE) begin
        quiet_q <= (board == prev_q) ? quiet_q + 7'd1 : 7'd0;
        tmo_q   <= tmo_q + 7'd1;
        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
      if (state_q == S_CHECK) game_over_q <= game_over_q | ~|node_movable;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT0, S_INIT1, S_SPAWN: if (scan_done) state_d = S_POST;
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  state_d = S_SETTLE;
      S_SETTLE: if (settle_exit) state_d = (board != snap_q) ? S_SPAWN : S_CHECK;
      S_POST:   state_d = ret_init1_q ? S_INIT1 : S_CHECK;
      S_CHECK:  state_d = S_IDLE;
      default:  state_d = S_INIT0;
    endcase
  end

  always_comb begin
    ack_d          = 1'b0;
    start_dir_d    = '0;
    preset_d       = 1'b0;
    preset_sel_d   = '0;
    preset_value_d = '0;
    moved_d        = 1'b0;
    busy_d         = (state_d != S_IDLE);
    if (accept) begin
      ack_d       = 1'b1;
      start_dir_d = 4'b0001 << move_dir;
    end
    if (is_scan && cell_empty) begin
      preset_d       = 1'b1;
      preset_sel_d   = 16'h0001 << probe_cell;
      preset_value_d = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end
    // Only a CHECK reached through a move's spawn counts as a board-changing move.
    if ((state_q == S_POST) && (state_d == S_CHECK) && from_spawn_q) moved_d = 1'b1;
  end

  assign move_ack     = ack_q;
  assign start_dir    = start_dir_q;
  assign preset       = preset_q;
  assign preset_sel   = preset_sel_q;
  assign preset_value = preset_value_q;
  assign score        = score_q;
  assign moved        = moved_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: init spawns, moves with and without change,
// timeout and dropped requests, score saturation, game over and reset clearing.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_req;
  logic [1:0]  move_dir;
  logic        move_ack;
  logic [63:0] board;
  logic [15:0] node_score;
  logic [31:0] node_movable;
  logic [3:0]  start_dir;
  logic        preset;
  logic [15:0] preset_sel;
  logic [3:0]  preset_value;
  logic [15:0] score;
  logic        moved;
  logic        busy;
  logic        game_over;
  logic [2:0]  dbg_state;

  localparam logic [2:0]  ST_IDLE   = 3'd2;
  localparam logic [2:0]  ST_SETTLE = 3'd4;
  localparam logic [2:0]  ST_SPAWN  = 3'd5;
  localparam logic [2:0]  ST_CHECK  = 3'd7;
  localparam logic [63:0] FULL_A    = 64'h1111_1111_1111_1111;
  localparam logic [63:0] FULL_B    = 64'h2222_2222_2222_2222;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk(clk), .rst(rst), .move_req(move_req), .move_dir(move_dir), .move_ack(move_ack),
    .board(board), .node_score(node_score), .node_movable(node_movable),
    .start_dir(start_dir), .preset(preset), .preset_sel(preset_sel),
    .preset_value(preset_value), .score(score), .moved(moved), .busy(busy),
    .game_over(game_over), .dbg_state(dbg_state)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // Reference Galois LFSR, mask 16'hB400, shifting right every cycle out of reset.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_c, output int n);
    n = 0;
    while (busy && n < max_c) begin
      step();
      n++;
    end
  endtask

  task automatic quiet_move(input logic [15:0] ns, output int n);
    node_score = ns;
    move_req   = 1'b1;
    step();
    move_req   = 1'b0;
    wait_idle(20, n);
  endtask

  initial begin
    int          n, settle_cnt, exp_k;
    logic        saw_preset, saw_moved, saw_ack, saw_dir, saw_busy;
    logic [15:0] l;
    logic [3:0]  s, c, exp_cell, exp_val;
    logic        found;

    rst = 1'b1; move_req = 1'b0; move_dir = 2'd0; board = '0;
    node_score = '0; node_movable = '1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_preset", preset, 0);

    // Reset release with an empty board: two init spawns at cells 1 and 8, value 1.
    rst = 1'b0;
    check("rel_score", score, 0);
    step();
    check("init0_preset", preset, 1);
    check("init0_sel", preset_sel, 16'h0002);
    check("init0_val", preset_value, 4'd1);
    check("init0_busy", busy, 1);
    step();
    check("init_gap", preset, 0);
    step();
    check("init1_preset", preset, 1);
    check("init1_sel", preset_sel, 16'h0100);
    check("init1_val", preset_value, 4'd1);
    step();
    check("init_check_state", dbg_state, ST_CHECK);
    check("init_moved", moved, 0);
    step();
    check("init_idle_busy", busy, 0);
    check("init_idle_state", dbg_state, ST_IDLE);
    check("init_gameover", game_over, 0);

    // Move left with change: cell 1 slides to cell 0 during the first SETTLE cycle.
    board = 64'h0000_0000_0000_0010; move_dir = 2'd2; move_req = 1'b1;
    step();
    move_req = 1'b0;
    check("left_ack", move_ack, 1);
    check("left_dir", start_dir, 4'b0100);
    check("left_preset_in_start", preset, 0);
    step();
    check("left_ack_once", move_ack, 0);
    board = 64'h0000_0000_0000_0001;
    repeat (6) step();
    check("left_spawn_state", dbg_state, ST_SPAWN);
    l = m_lfsr; s = l[3:0]; found = 1'b0; exp_cell = '0; exp_val = '0; exp_k = 0;
    for (int k = 0; k < 16; k++) begin
      c = s + k[3:0];
      if (!found && board[{c, 2'b00} +: 4] == 4'd0) begin
        found = 1'b1; exp_cell = c; exp_k = k;
        exp_val = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
      end
      l = lfsr_next(l);
    end
    repeat (exp_k + 1) step();
    check("left_preset", preset, 1);
    check("left_sel", preset_sel, 16'h0001 << exp_cell);
    check("left_val", preset_value, exp_val);
    step();
    check("left_moved", moved, 1);
    check("left_preset_off", preset, 0);
    step();
    check("left_moved_once", moved, 0);
    check("left_idle", busy, 0);

    // No-change move up: 5 SETTLE cycles, no spawn, back in IDLE 7 cycles after accept.
    move_dir = 2'd0; move_req = 1'b1;
    step();
    move_req = 1'b0;
    check("up_dir", start_dir, 4'b0001);
    n = 0; settle_cnt = 0; saw_preset = 1'b0; saw_moved = 1'b0;
    while (busy && n < 30) begin
      step(); n++;
      if (dbg_state == ST_SETTLE) settle_cnt++;
      if (preset) saw_preset = 1'b1;
      if (moved) saw_moved = 1'b1;
    end
    check("up_latency", n, 7);
    check("up_settle", settle_cnt, 5);
    check("up_no_preset", saw_preset, 0);
    check("up_no_moved", saw_moved, 0);

    // Timeout: board toggles every cycle; a request during SETTLE is dropped.
    board = FULL_A; move_dir = 2'd3; move_req = 1'b1;
    step();
    move_req = 1'b0;
    check("tmo_dir", start_dir, 4'b1000);
    n = 0; settle_cnt = 0; saw_ack = 1'b0;
    while (busy && n < 200) begin
      board    = (board == FULL_A) ? FULL_B : FULL_A;
      move_req = (n == 10);
      step(); n++;
      if (dbg_state == ST_SETTLE) settle_cnt++;
      if (move_ack) saw_ack = 1'b1;
    end
    move_req = 1'b0;
    check("tmo_idle", busy, 0);
    check("tmo_settle", settle_cnt, 64);
    check("tmo_drop_ack", saw_ack, 0);
    step();
    check("tmo_not_queued", move_ack, 0);
    check("tmo_score", score, 0);

    // Score ramp on a static full board: each quiet move adds 5 cycles x 16 merges.
    board = FULL_A;
    quiet_move(16'hFFFF, n);
    check("ramp_first", score, 16'd80);
    for (int i = 0; i < 818; i++) quiet_move(16'hFFFF, n);
    check("ramp_idle", busy, 0);
    check("ramp_total", score, 16'hFFF0);

    node_score = '0; move_req = 1'b1;
    step();
    move_req = 1'b0;
    step();
    node_score = 16'h3FFF;
    step();
    node_score = '0;
    wait_idle(20, n);
    check("pre_sat", score, 16'hFFFE);

    move_req = 1'b1;
    step();
    move_req = 1'b0;
    step();
    node_score = 16'h0003;
    step();
    check("sat_hit", score, 16'hFFFF);
    node_score = 16'hFFFF;
    wait_idle(20, n);
    node_score = '0;
    check("sat_hold", score, 16'hFFFF);

    // Game over: nothing movable at CHECK, then requests are refused.
    node_movable = '0;
    quiet_move(16'h0000, n);
    check("go_idle", busy, 0);
    check("go_set", game_over, 1);
    move_req = 1'b1; saw_ack = 1'b0; saw_dir = 1'b0; saw_busy = 1'b0;
    repeat (5) begin
      step();
      if (move_ack) saw_ack = 1'b1;
      if (start_dir != 4'd0) saw_dir = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    move_req = 1'b0;
    check("go_no_ack", saw_ack, 0);
    check("go_no_dir", saw_dir, 0);
    check("go_no_busy", saw_busy, 0);
    check("go_sticky", game_over, 1);

    // Only reset clears game over and the score.
    rst = 1'b1;
    #1;
    check("rst2_gameover", game_over, 0);
    check("rst2_score", score, 0);
    check("rst2_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
